// File: rtl/qlearn_step_sequencer_if.sv
// Bundled control, Q-RAM, environment and update-request signals of the Q-learning
// step sequencer; master is the sequencer side, slave the datapath/environment side.
interface qlearn_step_sequencer_if #(
    parameter int unsigned STATE_W = 6,
    parameter int unsigned DATA_W  = 16
) ();
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 goal_reached;
    logic [STATE_W-1:0]   cur_state;
    logic [7:0]           step_count;
    logic                 q_rd_en;
    logic [STATE_W+1:0]   q_rd_addr;
    logic [DATA_W-1:0]    q_rd_data;
    logic                 act_valid;
    logic                 act_ready;
    logic [1:0]           act;
    logic                 env_valid;
    logic [STATE_W-1:0]   env_next_state;
    logic [DATA_W-1:0]    env_reward;
    logic                 upd_valid;
    logic                 upd_ready;
    logic [STATE_W-1:0]   upd_state;
    logic [1:0]           upd_action;
    logic [DATA_W-1:0]    upd_reward;
    logic [STATE_W-1:0]   upd_next_state;

    modport master (
        input  start, q_rd_data, act_ready, env_valid, env_next_state, env_reward, upd_ready,
        output busy, done, goal_reached, cur_state, step_count, q_rd_en, q_rd_addr,
               act_valid, act, upd_valid, upd_state, upd_action, upd_reward, upd_next_state
    );

    modport slave (
        output start, q_rd_data, act_ready, env_valid, env_next_state, env_reward, upd_ready,
        input  busy, done, goal_reached, cur_state, step_count, q_rd_en, q_rd_addr,
               act_valid, act, upd_valid, upd_state, upd_action, upd_reward, upd_next_state
    );
endinterface

// File: rtl/qlearn_step_sequencer.sv
// Episode controller for the maze Q-learning datapath: scans Q-values, picks an action
// (greedy or epsilon-random), drives the environment and issues Q-update requests.
module qlearn_step_sequencer #(
    parameter int unsigned STATE_W     = 6,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned START_STATE = 0,
    parameter int unsigned GOAL_STATE  = 35,
    parameter int unsigned MAX_STEPS   = 255,
    parameter int unsigned EPSILON     = 26,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input logic                     clk,
    input logic                     rst_n,
    qlearn_step_sequencer_if.master bus
);
    localparam logic [STATE_W-1:0] START = STATE_W'(START_STATE);
    localparam logic [STATE_W-1:0] GOAL  = STATE_W'(GOAL_STATE);
    localparam logic [7:0]         LIMIT = 8'(MAX_STEPS);
    localparam logic [8:0]         EPS   = 9'(EPSILON);

    typedef enum logic [2:0] {
        StIdle, StScan, StAct, StWaitEnv, StUpdate, StCheck, StDone
    } state_e;

    state_e                   r_state, w_state_d;
    logic [2:0]               r_k;
    logic signed [DATA_W-1:0] r_max, w_q, w_best;
    logic [1:0]               r_max_idx, w_idx, w_best_idx;
    logic [1:0]               r_act;
    logic [7:0]               r_lfsr;
    logic                     w_lfsr_fb;
    logic [STATE_W-1:0]       r_cur;
    logic [7:0]               r_step;
    logic                     r_goal;
    logic [STATE_W-1:0]       r_upd_state, r_upd_next;
    logic [1:0]               r_upd_action;
    logic [DATA_W-1:0]        r_upd_reward;
    logic                     w_restart;

    assign w_restart = bus.start && ((r_state == StIdle) || (r_state == StDone));
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Scan cycle k compares the data read in cycle k-1; k == 1 seeds the running max.
    always_comb begin
        w_q   = bus.q_rd_data;
        w_idx = r_k[1:0] - 2'd1;
        if ((r_k == 3'd1) || (w_q > r_max)) begin
            w_best     = w_q;
            w_best_idx = w_idx;
        end else begin
            w_best     = r_max;
            w_best_idx = r_max_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d          = r_state;
        bus.busy           = 1'b1;
        bus.done           = 1'b0;
        bus.q_rd_en        = 1'b0;
        bus.q_rd_addr      = {r_cur, r_k[1:0]};
        bus.act_valid      = 1'b0;
        bus.upd_valid      = 1'b0;
        bus.act            = r_act;
        bus.cur_state      = r_cur;
        bus.step_count     = r_step;
        bus.goal_reached   = r_goal;
        bus.upd_state      = r_upd_state;
        bus.upd_action     = r_upd_action;
        bus.upd_reward     = r_upd_reward;
        bus.upd_next_state = r_upd_next;
        unique case (r_state)
            StIdle: begin
                bus.busy = 1'b0;
                if (w_restart) w_state_d = StScan;
            end
            StScan: begin
                bus.q_rd_en = (r_k < 3'd4);
                if (r_k == 3'd4) w_state_d = StAct;
            end
            StAct: begin
                bus.act_valid = 1'b1;
                if (bus.act_ready) w_state_d = StWaitEnv;
            end
            StWaitEnv: begin
                if (bus.env_valid) w_state_d = StUpdate;
            end
            StUpdate: begin
                bus.upd_valid = 1'b1;
                if (bus.upd_ready) w_state_d = StCheck;
            end
            StCheck: begin
                if ((r_cur == GOAL) || (r_step == LIMIT)) w_state_d = StDone;
                else                                       w_state_d = StScan;
            end
            StDone: begin
                bus.busy = 1'b0;
                bus.done = 1'b1;
                if (w_restart) w_state_d = StScan;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k          <= '0;
            r_max        <= '0;
            r_max_idx    <= '0;
            r_act        <= '0;
            r_lfsr       <= LFSR_SEED;
            r_cur        <= START;
            r_step       <= '0;
            r_goal       <= 1'b0;
            r_upd_state  <= '0;
            r_upd_action <= '0;
            r_upd_reward <= '0;
            r_upd_next   <= '0;
        end else begin
            r_k <= (r_state == StScan) ? r_k + 3'd1 : 3'd0;
            unique case (r_state)
                StIdle, StDone: begin
                    if (bus.start) begin
                        r_cur  <= START;
                        r_step <= '0;
                        r_goal <= 1'b0;
                    end
                end
                StScan: begin
                    if (r_k != 3'd0) begin
                        r_max     <= w_best;
                        r_max_idx <= w_best_idx;
                    end
                    // Decision uses the LFSR value before it steps.
                    if (r_k == 3'd4) begin
                        r_act  <= ({1'b0, r_lfsr} < EPS) ? r_lfsr[1:0] : w_best_idx;
                        r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
                    end
                end
                StWaitEnv: begin
                    if (bus.env_valid) begin
                        r_upd_state  <= r_cur;
                        r_upd_action <= r_act;
                        r_upd_reward <= bus.env_reward;
                        r_upd_next   <= bus.env_next_state;
                    end
                end
                StUpdate: begin
                    if (bus.upd_ready) begin
                        r_cur  <= r_upd_next;
                        r_step <= (r_step == 8'hFF) ? r_step : r_step + 8'd1;
                    end
                end
                StCheck: r_goal <= (r_cur == GOAL);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_qlearn_step_sequencer.sv
// Directed bench: instance A (greedy, 3-step limit) and instance B (always exploring).
module tb_qlearn_step_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        act_ready = 1'b0, env_valid = 1'b0, upd_ready = 1'b0;
    logic [5:0]  env_next = '0;
    logic [15:0] env_reward = '0;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    qlearn_step_sequencer_if #(.STATE_W(6), .DATA_W(16)) if_a ();
    qlearn_step_sequencer_if #(.STATE_W(6), .DATA_W(16)) if_b ();

    qlearn_step_sequencer #(.EPSILON(0), .MAX_STEPS(3)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a)
    );
    qlearn_step_sequencer #(.EPSILON(255), .MAX_STEPS(255)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b)
    );

    assign if_a.start = start_a;
    assign if_b.start = start_b;
    assign if_a.act_ready = act_ready;
    assign if_b.act_ready = act_ready;
    assign if_a.env_valid = env_valid;
    assign if_b.env_valid = env_valid;
    assign if_a.env_next_state = env_next;
    assign if_b.env_next_state = env_next;
    assign if_a.env_reward = env_reward;
    assign if_b.env_reward = env_reward;
    assign if_a.upd_ready = upd_ready;
    assign if_b.upd_ready = upd_ready;

    // State 0: {5,-3,12,12}; state 1: {-4,3,-1,2}; state 2: {0,0,0,7}; all else 0.
    function automatic logic [15:0] qval_a(input logic [7:0] addr);
        case (addr)
            8'h00: return 16'd5;
            8'h01: return 16'hFFFD;
            8'h02: return 16'd12;
            8'h03: return 16'd12;
            8'h04: return 16'hFFFC;
            8'h05: return 16'd3;
            8'h06: return 16'hFFFF;
            8'h07: return 16'd2;
            8'h0B: return 16'd7;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic [15:0] qval_b(input logic [7:0] addr);
        return (addr[1:0] == 2'd3) ? 16'd100 : 16'd0;
    endfunction

    always @(posedge clk) begin
        if (if_a.q_rd_en) if_a.q_rd_data <= qval_a(if_a.q_rd_addr);
        if (if_b.q_rd_en) if_b.q_rd_data <= qval_b(if_b.q_rd_addr);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Full step on instance A (sel=0) or B (sel=1); returns at the negedge in CHECK.
    task automatic do_step(input bit sel, input logic [5:0] nxt, input logic [15:0] rew,
                           output logic [1:0] act_o);
        int t = 0;
        while (!(sel ? if_b.act_valid : if_a.act_valid) && t < 40) begin
            tick();
            t++;
        end
        n_tests++;
        if (t >= 40) begin
            n_fail++;
            $display("FAIL step_act_valid: not seen within %0d cycles, required 1", t);
        end
        act_o = sel ? if_b.act : if_a.act;
        act_ready = 1'b1; tick(); act_ready = 1'b0;
        env_valid = 1'b1; env_next = nxt; env_reward = rew; tick(); env_valid = 1'b0;
        upd_ready = 1'b1; tick(); upd_ready = 1'b0;
    endtask

    task automatic wait_done_a();
        int t = 0;
        while (!if_a.done && t < 10) begin
            tick();
            t++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_tests++; if (if_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", if_a.busy); end
        n_tests++; if (if_a.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", if_a.done); end
        n_tests++; if (if_a.cur_state !== 6'd0) begin n_fail++; $display("FAIL reset_cur_state: got %0d want 0", if_a.cur_state); end
        n_tests++; if (if_a.step_count !== 8'd0) begin n_fail++; $display("FAIL reset_step_count: got %0d want 0", if_a.step_count); end
        n_tests++; if ({if_a.q_rd_en, if_a.act_valid, if_a.upd_valid, if_a.goal_reached} !== 4'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 0000", {if_a.q_rd_en, if_a.act_valid, if_a.upd_valid, if_a.goal_reached});
        end
        n_tests++; if ({if_a.upd_state, if_a.upd_action, if_a.upd_reward, if_a.upd_next_state} !== 30'd0) begin
            n_fail++; $display("FAIL reset_upd_tuple: got %h want 0", {if_a.upd_state, if_a.upd_action, if_a.upd_reward, if_a.upd_next_state});
        end
        rst_n = 1'b1;
        tick(); tick();
        n_tests++; if (if_a.busy !== 1'b0 || if_b.busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start: busy a=%b b=%b want 0 0", if_a.busy, if_b.busy); end
    endtask

    task automatic test_greedy();
        int t = 0, cyc = 0, naddr = 0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        while (!if_a.q_rd_en && t < 10) begin tick(); t++; end
        while (!if_a.act_valid && cyc < 20) begin
            if (if_a.q_rd_en) begin
                n_tests++;
                if (if_a.q_rd_addr !== {6'd0, 2'(naddr)}) begin
                    n_fail++; $display("FAIL greedy_rd_addr: got %h want %h", if_a.q_rd_addr, {6'd0, 2'(naddr)});
                end
                naddr++;
            end
            tick();
            cyc++;
        end
        n_tests++; if (naddr != 4) begin n_fail++; $display("FAIL greedy_rd_count: got %0d want 4", naddr); end
        n_tests++; if (cyc != 5) begin n_fail++; $display("FAIL greedy_act_latency: got %0d want 5", cyc); end
        n_tests++; if (if_a.act !== 2'd2) begin n_fail++; $display("FAIL greedy_act: got %0d want 2", if_a.act); end
    endtask

    task automatic test_handshake_stall();
        for (int i = 0; i < 7; i++) begin
            n_tests++;
            if (if_a.act_valid !== 1'b1 || if_a.act !== 2'd2 || if_a.q_rd_en !== 1'b0) begin
                n_fail++; $display("FAIL stall_act: valid=%b act=%0d rd_en=%b want 1 2 0", if_a.act_valid, if_a.act, if_a.q_rd_en);
            end
            tick();
        end
        act_ready = 1'b1; tick(); act_ready = 1'b0;
        n_tests++; if (if_a.act_valid !== 1'b0) begin n_fail++; $display("FAIL stall_act_single: got %b want 0", if_a.act_valid); end
        env_valid = 1'b1; env_next = 6'd34; env_reward = 16'hFFF9; tick(); env_valid = 1'b0;
        env_next = 6'd0; env_reward = 16'd0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (if_a.upd_valid !== 1'b1 || if_a.upd_state !== 6'd0 || if_a.upd_action !== 2'd2 ||
                if_a.upd_reward !== 16'hFFF9 || if_a.upd_next_state !== 6'd34 || if_a.step_count !== 8'd0) begin
                n_fail++; $display("FAIL stall_upd: v=%b s=%0d a=%0d r=%h n=%0d cnt=%0d want 1 0 2 fff9 34 0",
                    if_a.upd_valid, if_a.upd_state, if_a.upd_action, if_a.upd_reward, if_a.upd_next_state, if_a.step_count);
            end
            tick();
        end
        upd_ready = 1'b1; tick(); upd_ready = 1'b0;
        n_tests++; if (if_a.upd_valid !== 1'b0) begin n_fail++; $display("FAIL stall_upd_single: got %b want 0", if_a.upd_valid); end
        tick();
        n_tests++; if (if_a.step_count !== 8'd1) begin n_fail++; $display("FAIL stall_step_count: got %0d want 1", if_a.step_count); end
        n_tests++; if (if_a.cur_state !== 6'd34) begin n_fail++; $display("FAIL stall_cur_state: got %0d want 34", if_a.cur_state); end
    endtask

    task automatic test_goal();
        logic [1:0] a;
        do_step(1'b0, 6'd35, 16'd100, a);
        n_tests++; if (a !== 2'd0) begin n_fail++; $display("FAIL goal_tie_act: got %0d want 0", a); end
        wait_done_a();
        n_tests++; if (if_a.done !== 1'b1 || if_a.goal_reached !== 1'b1) begin
            n_fail++; $display("FAIL goal_done: done=%b goal=%b want 1 1", if_a.done, if_a.goal_reached);
        end
        n_tests++; if (if_a.cur_state !== 6'd35 || if_a.step_count !== 8'd2 || if_a.busy !== 1'b0) begin
            n_fail++; $display("FAIL goal_state: cur=%0d cnt=%0d busy=%b want 35 2 0", if_a.cur_state, if_a.step_count, if_a.busy);
        end
        n_tests++; if (if_a.upd_reward !== 16'd100) begin n_fail++; $display("FAIL goal_reward: got %0d want 100", if_a.upd_reward); end
    endtask

    task automatic test_step_limit();
        logic [1:0] a;
        start_a = 1'b1; tick(); start_a = 1'b0;
        n_tests++; if (if_a.done !== 1'b0 || if_a.busy !== 1'b1 || if_a.cur_state !== 6'd0 ||
                       if_a.step_count !== 8'd0 || if_a.goal_reached !== 1'b0) begin
            n_fail++; $display("FAIL limit_restart: done=%b busy=%b cur=%0d cnt=%0d goal=%b want 0 1 0 0 0",
                if_a.done, if_a.busy, if_a.cur_state, if_a.step_count, if_a.goal_reached);
        end
        do_step(1'b0, 6'd1, 16'd5, a);
        n_tests++; if (a !== 2'd2) begin n_fail++; $display("FAIL limit_act1: got %0d want 2", a); end
        tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        do_step(1'b0, 6'd2, 16'd5, a);
        n_tests++; if (a !== 2'd1) begin n_fail++; $display("FAIL limit_act_signed: got %0d want 1", a); end
        tick();
        n_tests++; if (if_a.done !== 1'b0 || if_a.step_count !== 8'd2) begin
            n_fail++; $display("FAIL limit_mid: done=%b cnt=%0d want 0 2", if_a.done, if_a.step_count);
        end
        do_step(1'b0, 6'd3, 16'd5, a);
        n_tests++; if (a !== 2'd3) begin n_fail++; $display("FAIL limit_act3: got %0d want 3", a); end
        wait_done_a();
        n_tests++; if (if_a.done !== 1'b1 || if_a.goal_reached !== 1'b0 || if_a.step_count !== 8'd3 || if_a.cur_state !== 6'd3) begin
            n_fail++; $display("FAIL limit_done: done=%b goal=%b cnt=%0d cur=%0d want 1 0 3 3",
                if_a.done, if_a.goal_reached, if_a.step_count, if_a.cur_state);
        end
        start_a = 1'b1; tick(); start_a = 1'b0;
        n_tests++; if (if_a.done !== 1'b0 || if_a.cur_state !== 6'd0 || if_a.step_count !== 8'd0) begin
            n_fail++; $display("FAIL limit_rerun: done=%b cur=%0d cnt=%0d want 0 0 0", if_a.done, if_a.cur_state, if_a.step_count);
        end
    endtask

    task automatic test_async_reset();
        int t = 0;
        while (!if_a.act_valid && t < 20) begin tick(); t++; end
        act_ready = 1'b1; tick(); act_ready = 1'b0;
        env_valid = 1'b1; env_next = 6'd7; env_reward = 16'd1; tick(); env_valid = 1'b0;
        n_tests++; if (if_a.upd_valid !== 1'b1 || if_a.busy !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_update: upd_valid=%b busy=%b want 1 1", if_a.upd_valid, if_a.busy);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (if_a.upd_valid !== 1'b0 || if_a.busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_drop: upd_valid=%b busy=%b want 0 0", if_a.upd_valid, if_a.busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        env_valid = 1'b1; env_next = 6'd9; env_reward = 16'd55; tick(); env_valid = 1'b0;
        tick();
        n_tests++; if (if_a.busy !== 1'b0 || if_a.upd_valid !== 1'b0 || if_a.done !== 1'b0) begin
            n_fail++; $display("FAIL rst_idle: busy=%b upd_valid=%b done=%b want 0 0 0", if_a.busy, if_a.upd_valid, if_a.done);
        end
        n_tests++; if (if_a.cur_state !== 6'd0 || if_a.upd_next_state !== 6'd0 || if_a.step_count !== 8'd0) begin
            n_fail++; $display("FAIL rst_spurious_env: cur=%0d upd_next=%0d cnt=%0d want 0 0 0",
                if_a.cur_state, if_a.upd_next_state, if_a.step_count);
        end
    endtask

    task automatic test_exploration();
        logic [1:0] a;
        logic [1:0] exp_act [5];
        // LFSR from A5: A5, 4A, 95, 2A, 54 -> low two bits.
        exp_act[0] = 2'd1; exp_act[1] = 2'd2; exp_act[2] = 2'd1; exp_act[3] = 2'd2; exp_act[4] = 2'd0;
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_step(1'b1, 6'(i + 1), 16'd0, a);
            n_tests++;
            if (a !== exp_act[i]) begin
                n_fail++; $display("FAIL explore_act%0d: got %0d want %0d", i, a, exp_act[i]);
            end
        end
        tick();
        n_tests++; if (if_b.step_count !== 8'd5 || if_b.done !== 1'b0) begin
            n_fail++; $display("FAIL explore_count: cnt=%0d done=%b want 5 0", if_b.step_count, if_b.done);
        end
    endtask

    initial begin
        test_reset();
        test_greedy();
        test_handshake_stall();
        test_goal();
        test_step_limit();
        test_async_reset();
        test_exploration();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/qlearn_step_sequencer.md
Name: qlearn_step_sequencer

Overview:
- Episode controller for the maze Q-learning datapath.
- Each step it scans the Q-RAM entries for the current state and picks an action: greedy, or random with epsilon probability.
- It then hands the action to the environment, collects the next state and reward, and issues a Q-update request carrying the (state, action, reward, next_state) tuple. This is the tuple the downstream delay stages align.
- It sequences steps until the goal state is reached or the step limit expires.

Parameters:
STATE_W, 6, state index width
DATA_W, 16, Q-value and reward width (signed two's complement)
START_STATE, 0, state loaded at episode start
GOAL_STATE, 35, terminal state
MAX_STEPS, 255, step limit per episode (1..255)
EPSILON, 26, exploration threshold on 8-bit LFSR (26/256 ≈ 10 %)
LFSR_SEED, 8'hA5, LFSR reset value (nonzero)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin episode (sampled only in IDLE)
busy  out  1  high in all states except IDLE and DONE
done  out  1  high while in DONE
goal_reached  out  1  valid with done: 1 = goal, 0 = step limit
cur_state  out  STATE_W  current state
step_count  out  8  steps completed in this episode
q_rd_en  out  1  Q-RAM read strobe
q_rd_addr  out  STATE_W+2  {cur_state, action}
q_rd_data  in  DATA_W  Q value; valid the cycle after q_rd_en
act_valid  out  1  action offer to environment
act_ready  in  1  environment accepts action
act  out  2  chosen action (0..3)
env_valid  in  1  environment response pulse
env_next_state  in  STATE_W  next state, qualified by env_valid
env_reward  in  DATA_W  reward, qualified by env_valid
upd_valid  out  1  Q-update request
upd_ready  in  1  update datapath accepts
upd_state  out  STATE_W  update tuple field, held stable while upd_valid
upd_action  out  2  update tuple field, held stable while upd_valid
upd_reward  out  DATA_W  update tuple field, held stable while upd_valid
upd_next_state  out  STATE_W  update tuple field, held stable while upd_valid

Behaviour:
- Reset (async, rst_n low):
  - State → IDLE.
  - All outputs 0, except cur_state = START_STATE.
  - LFSR = LFSR_SEED.
  - step_count = 0.
  - Reset mid-operation aborts immediately. No pending handshake survives reset.
- IDLE:
  - On start: cur_state ← START_STATE, step_count ← 0, goal_reached ← 0, go to SCAN.
- SCAN (5 cycles):
  - Cycles 0..3: q_rd_en = 1, q_rd_addr = {cur_state, k} for k = 0..3.
  - Cycles 1..4: compare returned q_rd_data (signed) against the running max. Action 0 initialises the max.
  - Strictly-greater replaces the max, so ties resolve to the lowest action index.
  - Go to ACT after cycle 4.
- Action choice:
  - At the SCAN→ACT transition, if lfsr < EPSILON, act ← lfsr[1:0]; otherwise act ← argmax.
  - LFSR is 8-bit Fibonacci, taps 8,6,5,4. It advances once per SCAN→ACT transition only.
- ACT:
  - act_valid = 1 with act stable.
  - Transfer occurs on act_valid & act_ready; go to WAIT_ENV on the next cycle.
- WAIT_ENV:
  - On env_valid, latch env_next_state and env_reward into the upd_* registers, along with cur_state and act. Go to UPDATE.
  - env_valid in any other state is ignored.
- UPDATE:
  - upd_valid = 1, tuple held stable until upd_valid & upd_ready.
  - On transfer: cur_state ← upd_next_state, step_count ← step_count + 1, go to CHECK.
- CHECK (1 cycle):
  - If cur_state == GOAL_STATE: goal_reached ← 1, go to DONE.
  - Else if step_count == MAX_STEPS: goal_reached ← 0, go to DONE.
  - Otherwise go to SCAN.
  - The goal condition takes priority when both conditions hold.
- DONE:
  - done = 1; outputs hold.
  - On start: restart as from IDLE; done drops the next cycle.
- Other rules:
  - start while busy is ignored.
  - step_count saturates at 255; it never wraps.
  - busy = 0 in IDLE and DONE.
  - At most one of q_rd_en, act_valid, upd_valid is high in any cycle.

Test Plan:
- Greedy pick: EPSILON = 0; Q[s0] = {5, -3, 12, 12} → act = 2 (tie → lower index); q_rd_addr sequence {0,0}..{0,3}; act_valid asserted exactly 5 cycles after SCAN entry.
- Handshake stalls: act_ready held low 7 cycles, upd_ready low 4 cycles → act, upd_* stable throughout; single transfer each; step_count increments by exactly 1.
- Goal termination: environment maps each step +1 state starting at 33, reward 100 on reaching 35 → done after 2 steps, goal_reached = 1, cur_state = 35, step_count = 2.
- Step limit: MAX_STEPS = 3, environment never reaches goal → done after step 3, goal_reached = 0, step_count = 3; start in DONE restarts with cur_state = 0, step_count = 0.
- Exploration: EPSILON = 256 equivalent (force lfsr < EPSILON always; use EPSILON = 255 with seed below it) → act equals lfsr[1:0] of the LFSR sequence from seed A5, not argmax.
- Async reset mid-UPDATE: rst_n low while upd_valid = 1 → upd_valid, busy drop without a clock edge; after release, state is IDLE, cur_state = 0, and a spurious env_valid is ignored.
